// File: rtl/shift_add_multiplier_ctrl_if.sv
// Handshake and partial-product bundle between the multiplier controller,
// its operand source, the partial-product stage and the product consumer.
interface shift_add_multiplier_ctrl_if #(
   parameter int WIDTH = 4
);
   localparam int SW = $clog2(WIDTH);

   logic               start;
   logic [WIDTH-1:0]   a;
   logic [WIDTH-1:0]   b;
   logic [WIDTH-1:0]   pp_a;
   logic               pp_b;
   logic [SW-1:0]      pp_shift;
   logic [2*WIDTH-1:0] pp_result;
   logic [2*WIDTH-1:0] product;
   logic               busy;
   logic               done;

   modport slave (
      input  start, a, b, pp_result,
      output pp_a, pp_b, pp_shift, product, busy, done
   );

   modport master (
      output start, a, b, pp_result,
      input  pp_a, pp_b, pp_shift, product, busy, done
   );
endinterface

// File: rtl/shift_add_multiplier_ctrl.sv
// Sequential shift-and-add multiplier controller: walks the multiplier one bit
// per cycle through an external partial-product stage and accumulates the result.
//
// state | meaning
// IDLE  | waiting for start; operands latched on accept
// RUN   | one multiplier bit per cycle, accumulating pp_result
// DONE  | one-cycle done pulse with product valid
module shift_add_multiplier_ctrl #(
   parameter int WIDTH = 4
) (
   input logic clk,
   input logic rst,
   shift_add_multiplier_ctrl_if.slave bus
);
   localparam int SW = $clog2(WIDTH);
   localparam logic [SW-1:0] LAST_IDX = SW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state;
   logic [WIDTH-1:0]   a_reg;
   logic [WIDTH-1:0]   b_reg;
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] product;
   logic [SW-1:0]      idx;
   logic               busy;
   logic               done;

   // Stage inputs are gated so the stage sees a zero bit outside RUN.
   assign bus.pp_a     = a_reg;
   assign bus.pp_b     = (state == RUN) ? b_reg[idx] : 1'b0;
   assign bus.pp_shift = (state == RUN) ? idx : '0;
   assign bus.product  = product;
   assign bus.busy     = busy;
   assign bus.done     = done;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         a_reg   <= '0;
         b_reg   <= '0;
         acc     <= '0;
         product <= '0;
         idx     <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               busy <= 1'b0;
               if (bus.start) begin
                  a_reg <= bus.a;
                  b_reg <= bus.b;
                  acc   <= '0;
                  idx   <= '0;
                  busy  <= 1'b1;
                  state <= RUN;
               end
            end
            RUN: begin
               acc <= acc + bus.pp_result;
               if (idx == LAST_IDX) begin
                  product <= acc + bus.pp_result;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  state   <= DONE;
               end else begin
                  idx <= idx + SW'(1);
               end
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_shift_add_multiplier_ctrl.sv
// Scoreboard bench for shift_add_multiplier_ctrl: a 4-bit and an 8-bit instance,
// each with a behavioural partial-product stage and a done-driven monitor.
module tb_shift_add_multiplier_ctrl;
   localparam int W4 = 4;
   localparam int W8 = 8;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   logic [2*W4-1:0] q4[$];
   logic [2*W8-1:0] q8[$];

   shift_add_multiplier_ctrl_if #(.WIDTH(W4)) bus4 ();
   shift_add_multiplier_ctrl_if #(.WIDTH(W8)) bus8 ();

   shift_add_multiplier_ctrl #(.WIDTH(W4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
   shift_add_multiplier_ctrl #(.WIDTH(W8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

   assign bus4.pp_result = bus4.pp_b ? ({{W4{1'b0}}, bus4.pp_a} << bus4.pp_shift) : '0;
   assign bus8.pp_result = bus8.pp_b ? ({{W8{1'b0}}, bus8.pp_a} << bus8.pp_shift) : '0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   always @(negedge clk) begin
      if (bus4.done) begin
         total++;
         if (q4.size() == 0) begin
            bad++;
            $display("FAIL done4_unexpected product=%0d required=no_done", bus4.product);
         end else begin
            logic [2*W4-1:0] e4;
            e4 = q4.pop_front();
            if (bus4.product !== e4) begin
               bad++;
               $display("FAIL product4 got=%0d required=%0d", bus4.product, e4);
            end
         end
      end
      if (bus8.done) begin
         total++;
         if (q8.size() == 0) begin
            bad++;
            $display("FAIL done8_unexpected product=%0d required=no_done", bus8.product);
         end else begin
            logic [2*W8-1:0] e8;
            e8 = q8.pop_front();
            if (bus8.product !== e8) begin
               bad++;
               $display("FAIL product8 got=%0d required=%0d", bus8.product, e8);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   // Full operation on the 4-bit instance, checking per-cycle stage drive and latency.
   task automatic run_op(input logic [3:0] av, input logic [3:0] bv, input logic [7:0] exp);
      bus4.a = av;
      bus4.b = bv;
      bus4.start = 1'b1;
      q4.push_back(exp);
      cyc();
      bus4.start = 1'b0;
      for (int k = 0; k < W4; k++) begin
         chk("run_busy", 32'(bus4.busy), 32'd1);
         chk("run_shift", 32'(bus4.pp_shift), 32'(k));
         chk("run_ppb", 32'(bus4.pp_b), 32'(bv[k]));
         chk("run_done_low", 32'(bus4.done), 32'd0);
         cyc();
      end
      chk("done_high", 32'(bus4.done), 32'd1);
      chk("done_busy_low", 32'(bus4.busy), 32'd0);
      cyc();
      chk("done_one_cycle", 32'(bus4.done), 32'd0);
      chk("idle_busy_low", 32'(bus4.busy), 32'd0);
   endtask

   initial begin
      int n;
      int max_shift;
      total = 0;
      bad = 0;
      rst = 1'b1;
      bus4.start = 1'b0;
      bus4.a = '0;
      bus4.b = '0;
      bus8.start = 1'b0;
      bus8.a = '0;
      bus8.b = '0;
      cyc();
      cyc();
      chk("rst_product", 32'(bus4.product), 32'd0);
      chk("rst_busy", 32'(bus4.busy), 32'd0);
      chk("rst_done", 32'(bus4.done), 32'd0);
      chk("rst_ppshift", 32'(bus4.pp_shift), 32'd0);
      chk("rst_product8", 32'(bus8.product), 32'd0);
      rst = 1'b0;
      cyc();

      // basic and corner values
      run_op(4'd13, 4'd11, 8'd143);
      run_op(4'd15, 4'd15, 8'd225);
      run_op(4'd0,  4'd9,  8'd0);
      run_op(4'd9,  4'd0,  8'd0);

      // start while busy is ignored; operands not re-latched
      bus4.a = 4'd3;
      bus4.b = 4'd5;
      bus4.start = 1'b1;
      q4.push_back(8'd15);
      cyc();
      bus4.start = 1'b0;
      cyc();
      bus4.a = 4'd7;
      bus4.b = 4'd7;
      bus4.start = 1'b1;
      cyc();
      bus4.start = 1'b0;
      n = 0;
      while (!bus4.done && n < 20) begin
         cyc();
         n++;
      end
      chk("busy_start_done_seen", 32'(bus4.done), 32'd1);
      for (int k = 0; k < 4; k++) cyc();
      chk("busy_start_single_done", 32'(q4.size()), 32'd0);
      run_op(4'd6, 4'd7, 8'd42);

      // reset during the second RUN cycle
      bus4.a = 4'd12;
      bus4.b = 4'd12;
      bus4.start = 1'b1;
      cyc();
      bus4.start = 1'b0;
      cyc();
      rst = 1'b1;
      #1;
      chk("abort_busy", 32'(bus4.busy), 32'd0);
      chk("abort_done", 32'(bus4.done), 32'd0);
      chk("abort_product", 32'(bus4.product), 32'd0);
      cyc();
      rst = 1'b0;
      for (int k = 0; k < 8; k++) cyc();
      chk("abort_product_stays", 32'(bus4.product), 32'd0);
      run_op(4'd2, 4'd3, 8'd6);

      // back-to-back with start held high
      bus4.a = 4'd5;
      bus4.b = 4'd6;
      bus4.start = 1'b1;
      q4.push_back(8'd30);
      n = 0;
      do begin
         cyc();
         n++;
      end while (!bus4.done && n < 20);
      chk("b2b_first_latency", 32'(n), 32'd5);
      bus4.a = 4'd4;
      bus4.b = 4'd4;
      q4.push_back(8'd16);
      for (int k = 1; k <= 6; k++) begin
         cyc();
         if (k == 2) begin
            chk("b2b_accept_busy", 32'(bus4.busy), 32'd1);
            bus4.start = 1'b0;
         end
         if (k < 6) begin
            chk("b2b_product_hold", 32'(bus4.product), 32'd30);
            chk("b2b_no_done", 32'(bus4.done), 32'd0);
         end else begin
            chk("b2b_second_done", 32'(bus4.done), 32'd1);
         end
      end
      cyc();
      cyc();

      // 8-bit instance
      bus8.a = 8'd255;
      bus8.b = 8'd255;
      bus8.start = 1'b1;
      q8.push_back(16'd65025);
      cyc();
      bus8.start = 1'b0;
      n = 0;
      max_shift = 0;
      while (bus8.busy && n < 30) begin
         if (int'(bus8.pp_shift) > max_shift) max_shift = int'(bus8.pp_shift);
         cyc();
         n++;
      end
      chk("w8_run_cycles", 32'(n), 32'd8);
      chk("w8_max_shift", 32'(max_shift), 32'd7);
      chk("w8_done", 32'(bus8.done), 32'd1);
      cyc();
      cyc();

      chk("q4_drained", 32'(q4.size()), 32'd0);
      chk("q8_drained", 32'(q8.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
